// File: rtl/serv_immenc_pkg.sv
// Shared definitions for the bit-serial immediate encoder.
//   - Format codes (shared with the immediate decoder).
//   - fmt_reserved(): true for codes the encoder cannot place.
//   - FSM state encoding.
package serv_immenc_pkg;

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_Z = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic fmt_reserved(input logic [2:0] fmt);
    return (fmt > FMT_Z);
  endfunction

endpackage

// File: rtl/serv_immenc_scatter.sv
// Combinational field scatter: places immediate bits into the instruction
// positions of the selected format; all other bits come from base.
// Reserved formats return base unchanged.
//   fmt  in  3   format code
//   base in  32  base instruction word
//   imm  in  32  full immediate
//   insn out 32  merged instruction word
module serv_immenc_scatter
  import serv_immenc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  output logic [31:0] insn
);

  always_comb begin
    insn = base;
    case (fmt)
      FMT_I: begin
        insn[31:20] = imm[11:0];
      end
      FMT_S: begin
        insn[11:7]  = imm[4:0];
        insn[31:25] = imm[11:5];
      end
      FMT_B: begin
        insn[11:8]  = imm[4:1];
        insn[30:25] = imm[10:5];
        insn[7]     = imm[11];
        insn[31]    = imm[12];
      end
      FMT_U: begin
        insn[31:12] = imm[31:12];
      end
      FMT_J: begin
        insn[30:21] = imm[10:1];
        insn[20]    = imm[11];
        insn[19:12] = imm[19:12];
        insn[31]    = imm[20];
      end
      FMT_Z: begin
        insn[19:15] = imm[4:0];
      end
      default: insn = base;
    endcase
  end

endmodule

// File: rtl/serv_immenc.sv
// Bit-serial immediate encoder. Collects a 32-bit immediate LSB first,
// scatters it into the fields of the selected format over a base word and
// flags immediates the format cannot represent.
//
// Handshake: a request is accepted on i_start when o_busy=0. The result is
// offered with o_valid=1 and held stable until the cycle where
// o_valid && i_ready, after which o_valid/o_busy drop on the next cycle.
//
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           start request (ignored while busy)
//   i_fmt, i_base     format code and base word, sampled with i_start
//   i_en, i_imm       serial bit strobe and data, LSB first
//   o_busy            request in flight
//   o_valid, i_ready  result handshake
//   o_insn, o_err     merged word, not-representable flag
//
// The internal signal `state` carries the FSM state for debug visibility.
module serv_immenc
  import serv_immenc_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_fmt,
  input  logic [31:0] i_base,
  input  logic        i_en,
  input  logic        i_imm,
  output logic        o_busy,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_insn,
  output logic        o_err
);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  fmt_q;
  logic [31:0] base_q;
  logic [31:0] sr;
  logic [4:0]  cnt;
  logic        ref_q;
  logic        err_q;

  logic [31:0] imm_full;
  logic [31:0] insn_w;
  logic        bit_err;
  logic        use_ref;
  logic [4:0]  ref_idx;
  logic        shift_en;
  logic        last_bit;

  // Right shift: after 32 samples sr holds the immediate in natural order.
  // imm_full is the completed word on the cycle the last bit arrives.
  assign imm_full = {i_imm, sr[31:1]};
  assign shift_en = (state == ST_SHIFT) && i_en;
  assign last_bit = shift_en && (cnt == 5'd31);

  // Sign-reference bit position for sign-extended formats.
  always_comb begin
    use_ref = 1'b0;
    ref_idx = 5'd0;
    case (fmt_q)
      FMT_I, FMT_S: begin use_ref = 1'b1; ref_idx = 5'd11; end
      FMT_B:        begin use_ref = 1'b1; ref_idx = 5'd12; end
      FMT_J:        begin use_ref = 1'b1; ref_idx = 5'd20; end
      default:      begin use_ref = 1'b0; ref_idx = 5'd0;  end
    endcase
  end

  // Per-bit representability check of the bit arriving at index cnt.
  // Bits above the reference must match the captured sign bit.
  always_comb begin
    bit_err = 1'b0;
    case (fmt_q)
      FMT_I, FMT_S: bit_err = (cnt > 5'd11) && (i_imm != ref_q);
      FMT_B:        bit_err = ((cnt == 5'd0) && i_imm) ||
                              ((cnt > 5'd12) && (i_imm != ref_q));
      FMT_U:        bit_err = (cnt < 5'd12) && i_imm;
      FMT_J:        bit_err = ((cnt == 5'd0) && i_imm) ||
                              ((cnt > 5'd20) && (i_imm != ref_q));
      FMT_Z:        bit_err = (cnt > 5'd4) && i_imm;
      default:      bit_err = 1'b0;
    endcase
  end

  serv_immenc_scatter u_scatter (
    .fmt  (fmt_q),
    .base (base_q),
    .imm  (imm_full),
    .insn (insn_w)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
      ST_DONE:  if (i_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fmt_q  <= 3'd0;
      base_q <= 32'd0;
      sr     <= 32'd0;
      cnt    <= 5'd0;
      ref_q  <= 1'b0;
      err_q  <= 1'b0;
      o_insn <= 32'd0;
      o_err  <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && i_start) begin
        fmt_q  <= i_fmt;
        base_q <= i_base;
        cnt    <= 5'd0;
        ref_q  <= 1'b0;
        err_q  <= 1'b0;
      end
      if (shift_en) begin
        sr  <= imm_full;
        cnt <= cnt + 5'd1;
        if (bit_err) err_q <= 1'b1;
        if (use_ref && (cnt == ref_idx)) ref_q <= i_imm;
        if (last_bit) begin
          o_insn <= insn_w;
          o_err  <= err_q | bit_err | fmt_reserved(fmt_q);
        end
      end
    end
  end

  assign o_busy  = (state != ST_IDLE);
  assign o_valid = (state == ST_DONE);

endmodule

// File: tb/tb_serv_immenc.sv
module tb_serv_immenc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  fmt;
  logic [31:0] base;
  logic        en;
  logic        imm_bit;
  logic        busy;
  logic        valid;
  logic        ready;
  logic [31:0] insn;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serv_immenc dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_fmt   (fmt),
    .i_base  (base),
    .i_en    (en),
    .i_imm   (imm_bit),
    .o_busy  (busy),
    .o_valid (valid),
    .i_ready (ready),
    .o_insn  (insn),
    .o_err   (err)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: field placement by concatenation, representability by
  // value range of the signed immediate.
  function automatic void model(input logic [2:0] f, input logic [31:0] b,
                                input logic [31:0] v,
                                output logic [31:0] m_insn, output logic m_err);
    longint s;
    s = longint'($signed(v));
    case (f)
      3'd0: begin
        m_insn = {v[11:0], b[19:0]};
        m_err  = !(s >= -2048 && s <= 2047);
      end
      3'd1: begin
        m_insn = {v[11:5], b[24:12], v[4:0], b[6:0]};
        m_err  = !(s >= -2048 && s <= 2047);
      end
      3'd2: begin
        m_insn = {v[12], v[10:5], b[24:12], v[4:1], v[11], b[6:0]};
        m_err  = (s % 2 != 0) || !(s >= -4096 && s <= 4095);
      end
      3'd3: begin
        m_insn = {v[31:12], b[11:0]};
        m_err  = (v % 4096) != 0;
      end
      3'd4: begin
        m_insn = {v[20], v[10:1], v[11], v[19:12], b[11:0]};
        m_err  = (s % 2 != 0) || !(s >= -1048576 && s <= 1048575);
      end
      3'd5: begin
        m_insn = {b[31:20], v[4:0], b[14:0]};
        m_err  = v > 32'd31;
      end
      default: begin
        m_insn = b;
        m_err  = 1'b1;
      end
    endcase
  endfunction

  // One full transaction: start, stream 32 bits, hold in DONE, handshake.
  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] b,
                     input logic [31:0] v, input bit gaps, input bit pulse,
                     input int hold);
    int n;
    int k;
    logic [31:0] e_insn;
    logic        e_err;
    logic [31:0] held_insn;
    logic        held_err;
    model(f, b, v, e_insn, e_err);
    // Cycle 0: start; with gaps, also a stray bit that must not be sampled.
    start   = 1'b1;
    fmt     = f;
    base    = b;
    en      = gaps;
    imm_bit = ~v[0];
    ready   = 1'b0;
    step();
    n = 1;
    k = 0;
    fmt  = 3'($urandom);
    base = $urandom;
    while (!valid && n < 400) begin
      if (k < 32 && (!gaps || $urandom_range(0, 2) != 0)) begin
        en      = 1'b1;
        imm_bit = v[k];
        k++;
      end else begin
        en      = gaps && (k >= 32);
        imm_bit = 1'($urandom);
      end
      start = pulse && ($urandom_range(0, 3) == 0);
      step();
      n++;
    end
    start = 1'b0;
    en    = 1'b0;
    check({tag, "_valid"}, 32'(valid), 32'd1);
    if (!gaps) check({tag, "_latency"}, n, 33);
    check({tag, "_insn"}, insn, e_insn);
    check({tag, "_err"}, 32'(err), 32'(e_err));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    held_insn = e_insn;
    held_err  = e_err;
    for (int i = 0; i < hold; i++) begin
      ready   = 1'b0;
      start   = 1'b1;
      fmt     = 3'($urandom);
      base    = $urandom;
      en      = 1'b1;
      imm_bit = 1'($urandom);
      step();
      check({tag, "_hold_valid"}, 32'(valid), 32'd1);
      check({tag, "_hold_insn"}, insn, held_insn);
      check({tag, "_hold_err"}, 32'(err), 32'(held_err));
    end
    start = 1'b0;
    en    = 1'b0;
    ready = 1'b1;
    step();
    ready = 1'b0;
    check({tag, "_post_valid"}, 32'(valid), 32'd0);
    check({tag, "_post_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    logic [2:0]  f;
    int          mode;
    rst = 1'b1; start = 1'b0; fmt = 3'd0; base = 32'd0;
    en = 1'b0; imm_bit = 1'b0; ready = 1'b0;
    step();
    step();
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_insn",  insn,       32'd0);
    check("rst_err",   32'(err),   32'd0);
    rst = 1'b0;
    step();

    // Directed cases with fixed expectations.
    run("i_neg1", 3'd0, 32'h00000013, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    run("i_big",  3'd0, 32'h00000013, 32'h00000800, 1'b0, 1'b0, 0);
    check("i_big_err_const", 32'(err), 32'd1);
    run("u_ok",   3'd3, 32'h00000037, 32'h12345000, 1'b0, 1'b0, 0);
    check("u_ok_insn_const", insn, 32'h12345037);
    run("u_bad",  3'd3, 32'h00000037, 32'h12345001, 1'b0, 1'b0, 0);
    run("b_neg2", 3'd2, 32'h00000063, 32'hFFFFFFFE, 1'b0, 1'b0, 0);
    check("b_neg2_insn_const", insn, 32'hFE000FE3);
    run("j_8",    3'd4, 32'h0000006F, 32'h00000008, 1'b0, 1'b0, 0);
    check("j_8_insn_const", insn, 32'h0080006F);
    run("j_9",    3'd4, 32'h0000006F, 32'h00000009, 1'b0, 1'b0, 0);
    run("z_1f",   3'd5, 32'h00005073, 32'h0000001F, 1'b0, 1'b0, 0);
    check("z_1f_insn_const", insn, 32'h000FD073);
    run("z_20",   3'd5, 32'h00005073, 32'h00000020, 1'b0, 1'b0, 0);
    run("rsv6",   3'd6, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1'b0, 0);
    run("s_m5",   3'd1, 32'h00000023, 32'hFFFFFFFB, 1'b0, 1'b0, 0);

    // Gaps, start pulses mid-shift, consumer stall in DONE.
    run("gap_i",  3'd0, 32'h00000013, 32'hFFFFF9A5, 1'b1, 1'b1, 5);

    // Reset after 10 sampled bits.
    start = 1'b1; fmt = 3'd0; base = 32'h00000013; en = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      en = 1'b1; imm_bit = 1'($urandom);
      step();
    end
    en = 1'b0;
    rst = 1'b1;
    step();
    check("midrst_busy",  32'(busy),  32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_insn",  insn,       32'd0);
    check("midrst_err",   32'(err),   32'd0);
    rst = 1'b0;
    step();
    run("after_rst", 3'd0, 32'h00000013, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    check("after_rst_const", insn, 32'hFFF00013);

    // Randomized transactions against the model.
    for (int t = 0; t < 40; t++) begin
      f    = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 3);
      case (mode)
        0:       v = $urandom;
        1:       v = 32'($signed($urandom_range(0, 8191)) - 4096);
        2:       v = $urandom << 12;
        default: v = 32'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 1) == 0) v[0] = 1'b0;
      run("rand", f, $urandom, v, bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serv_immenc.md
# serv_immenc

Bit-serial immediate encoder: the inverse of the core's immediate decoder. Accepts a 32-bit immediate streamed LSB first, one bit per enabled cycle, scatters the bits into the RISC-V instruction-field positions of a selected format (I/S/B/U/J/CSR-zimm), and merges them into a caller-supplied base instruction word. It also flags immediates the format cannot represent. It sits beside the bit-serial datapath and is used by debug/trap logic that synthesizes instruction words from serial ALU results.

## Interface
- No parameters.
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_start  in  1  start request; accepted only when o_busy=0
- i_fmt  in  3  format code, sampled with i_start: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (CSR zimm), 6/7 reserved
- i_base  in  32  base instruction word, sampled with i_start
- i_en  in  1  serial bit strobe
- i_imm  in  1  immediate bit, valid when i_en=1, LSB first
- o_busy  out  1  high from start acceptance until output handshake completes
- o_valid  out  1  encoded word available
- i_ready  in  1  consumer accepts o_insn/o_err when o_valid=1
- o_insn  out  32  merged instruction word
- o_err  out  1  immediate not representable in i_fmt

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: i_start=1 latches i_fmt/i_base, clears bit counter and error flag, goes to SHIFT.
- SHIFT: each i_en=1 cycle shifts i_imm into a 32-bit register and increments a 5-bit counter. When the counter wraps after bit 31 is sampled, go to DONE. Cycles with i_en=0 hold all state.
- DONE: o_valid=1. On i_ready=1, go to IDLE.
- Field placement: fields not listed keep the i_base bits.
  - I: imm[11:0]→[31:20].
  - S: imm[4:0]→[11:7]; imm[11:5]→[31:25].
  - B: imm[4:1]→[11:8]; imm[10:5]→[30:25]; imm[11]→[7]; imm[12]→[31].
  - U: imm[31:12]→[31:12].
  - J: imm[10:1]→[30:21]; imm[11]→[20]; imm[19:12]→[19:12]; imm[20]→[31].
  - Z: imm[4:0]→[19:15].
- Error rules (o_err=1):
  - I/S: any imm[31:12] ≠ imm[11].
  - B: imm[0]=1, or any imm[31:13] ≠ imm[12].
  - U: imm[11:0] ≠ 0.
  - J: imm[0]=1, or any imm[31:21] ≠ imm[20].
  - Z: imm[31:5] ≠ 0.
  - Reserved fmt: always error; o_insn = i_base.
- Error detection is incremental during SHIFT; the full word is not re-scanned. The sign reference bit is captured at its index, and each later bit is compared against it as it arrives. Zero-required bits are checked as they arrive.
- o_insn is still produced when o_err=1, using the truncated field bits.

## Timing
- Reset values: state=IDLE, o_busy=0, o_valid=0, o_insn=0, o_err=0, counter=0.
- Latency: i_start accepted at cycle 0. The earliest bit is sampled at cycle 1. o_valid rises the cycle after the 32nd sampled bit, so the minimum is 33 cycles from start to o_valid.
- i_start while o_busy=1 is ignored. i_en in IDLE or DONE is ignored.
- i_start and i_en in the same IDLE cycle: start is accepted, that bit is not sampled.
- o_insn/o_err are registered and stable while o_valid=1 && i_ready=0.
- o_valid && i_ready: o_valid=0 and o_busy=0 next cycle. A new i_start is accepted earliest that cycle.
- i_rst mid-SHIFT or in DONE: return to reset values next cycle, with no output handshake.

## Structure
- Shared package/header: format codes FMT_I..FMT_Z, the reserved-code check, and state encodings. The decoder uses the same format codes.
- Sub-module serv_immenc_scatter: purely combinational. It maps {fmt, base, imm[31:0]} to o_insn. The top module holds the FSM, counter, shift register and incremental error tracking.

## Test plan
- I, base 0x00000013, imm 0xFFFFFFFF → o_insn 0xFFF00013, o_err 0, o_valid exactly 33 cycles after start with i_en held at 1.
- I, imm 0x00000800 → o_err 1. U, imm 0x12345000, base 0x00000037 → 0x12345037, err 0. U, imm 0x12345001 → err 1.
- B, base 0x00000063, imm 0xFFFFFFFE → 0xFE000FE3, err 0. J, base 0x0000006F, imm 8 → 0x0080006F, err 0. J, imm 9 → err 1.
- Z, base 0x00005073, imm 0x1F → 0x000FD073, err 0. Z, imm 0x20 → err 1. fmt=6 → err 1, o_insn=base.
- Random i_en gaps, i_start pulsed mid-SHIFT, i_ready low for 5 cycles in DONE → result unchanged, output stable, no second start taken.
- i_rst after 10 bits sampled → all outputs 0 next cycle. A fresh I/-1 run then yields 0xFFF00013.
